// File: rtl/sum_latch_seq_ctrl.sv
// Sequencer for the nibble latch pair and UART TX: turns request edges into latch
// save strobes, captures the 5-bit sum, and streams it as ASCII hex (+ optional CR).
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting; launches one pending sequence (A > B > send)
// S_STROBE_A | save_a_n low for this single cycle
// S_STROBE_B | save_b_n low for this single cycle
// S_SETTLE   | latch output settling after the strobe edge
// S_CAPTURE  | sum_out <= q_a + q_b; optional auto-send after a B save
// S_SEND_HI  | presenting ASCII of sum bit 4
// S_SEND_LO  | presenting ASCII hex of sum bits 3:0
// S_SEND_CR  | presenting carriage return (only when SEND_CR=1)
module sum_latch_seq_ctrl #(
  parameter bit SEND_CR   = 1'b1,
  parameter bit AUTO_SEND = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_save_a,
  input  logic       req_save_b,
  input  logic       req_send,
  input  logic [3:0] q_a,
  input  logic [3:0] q_b,
  output logic       save_a_n,
  output logic       save_b_n,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [4:0] sum_out,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STROBE_A,
    S_STROBE_B,
    S_SETTLE,
    S_CAPTURE,
    S_SEND_HI,
    S_SEND_LO,
    S_SEND_CR
  } state_t;

  state_t     state, state_nxt;
  logic       prev_a, prev_b, prev_send;
  logic       pend_a, pend_b, pend_send;
  logic       seq_b;
  logic [4:0] tx_buf;
  logic [4:0] sum_new;
  logic       in_send;
  logic       launch_a, launch_b, launch_send, load_auto;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) return 8'h30 + {4'h0, n};
    else           return 8'h37 + {4'h0, n};
  endfunction

  assign sum_new = {1'b0, q_a} + {1'b0, q_b};
  assign in_send = (state == S_SEND_HI) || (state == S_SEND_LO) || (state == S_SEND_CR);

  always_comb begin
    state_nxt   = state;
    launch_a    = 1'b0;
    launch_b    = 1'b0;
    launch_send = 1'b0;
    load_auto   = 1'b0;
    save_a_n    = 1'b1;
    save_b_n    = 1'b1;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (pend_a) begin
          state_nxt = S_STROBE_A;
          launch_a  = 1'b1;
        end else if (pend_b) begin
          state_nxt = S_STROBE_B;
          launch_b  = 1'b1;
        end else if (pend_send) begin
          state_nxt   = S_SEND_HI;
          launch_send = 1'b1;
        end
      end
      S_STROBE_A: begin
        save_a_n  = 1'b0;
        state_nxt = S_SETTLE;
      end
      S_STROBE_B: begin
        save_b_n  = 1'b0;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: state_nxt = S_CAPTURE;
      S_CAPTURE: begin
        if (seq_b && AUTO_SEND) begin
          state_nxt = S_SEND_HI;
          load_auto = 1'b1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_SEND_HI: begin
        tx_valid = 1'b1;
        tx_data  = {7'b0011000, tx_buf[4]};
        if (tx_ready) state_nxt = S_SEND_LO;
      end
      S_SEND_LO: begin
        tx_valid = 1'b1;
        tx_data  = hex_ascii(tx_buf[3:0]);
        if (tx_ready) state_nxt = SEND_CR ? S_SEND_CR : S_IDLE;
      end
      S_SEND_CR: begin
        tx_valid = 1'b1;
        tx_data  = 8'h0D;
        if (tx_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Edge flops track the request levels even in reset so a level held high
  // through reset never looks like a fresh edge afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      prev_a    <= req_save_a;
      prev_b    <= req_save_b;
      prev_send <= req_send;
      pend_a    <= 1'b0;
      pend_b    <= 1'b0;
      pend_send <= 1'b0;
      seq_b     <= 1'b0;
      sum_out   <= 5'd0;
      tx_buf    <= 5'd0;
    end else begin
      state     <= state_nxt;
      prev_a    <= req_save_a;
      prev_b    <= req_save_b;
      prev_send <= req_send;
      pend_a    <= (pend_a & ~launch_a) | (req_save_a & ~prev_a);
      pend_b    <= (pend_b & ~launch_b) | (req_save_b & ~prev_b);
      pend_send <= (pend_send & ~launch_send) | (req_send & ~prev_send & ~in_send);
      if (launch_a)      seq_b <= 1'b0;
      else if (launch_b) seq_b <= 1'b1;
      if (state == S_CAPTURE) sum_out <= sum_new;
      // Snapshot so later saves cannot change bytes already in flight.
      if (launch_send)    tx_buf <= sum_out;
      else if (load_auto) tx_buf <= sum_new;
    end
  end

endmodule

// File: tb/tb_sum_latch_seq_ctrl.sv
// Scoreboard bench for sum_latch_seq_ctrl: a latch model feeds q_a/q_b, a nibble-level
// reference model predicts sums and TX bytes, and monitors compare against the DUT.
module tb_sum_latch_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       req_save_a, req_save_b, req_send, tx_ready;
  logic [3:0] data_in;
  logic [3:0] q_a = 4'h0, q_b = 4'h0;
  logic       save_a_n, save_b_n, tx_valid, busy;
  logic [7:0] tx_data;
  logic [4:0] sum_out;

  logic       req2_a, req2_b, req2_send;
  logic [3:0] data2;
  logic [3:0] q2_a = 4'h0, q2_b = 4'h0;
  logic       save2_a_n, save2_b_n, tx2_valid, busy2;
  logic       tx2_ready = 1'b1;
  logic [7:0] tx2_data;
  logic [4:0] sum2_out;

  sum_latch_seq_ctrl dut (
    .clk(clk), .reset(reset), .req_save_a(req_save_a), .req_save_b(req_save_b),
    .req_send(req_send), .q_a(q_a), .q_b(q_b), .save_a_n(save_a_n), .save_b_n(save_b_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .sum_out(sum_out), .busy(busy)
  );

  sum_latch_seq_ctrl #(.SEND_CR(1'b0), .AUTO_SEND(1'b1)) dut2 (
    .clk(clk), .reset(reset), .req_save_a(req2_a), .req_save_b(req2_b),
    .req_send(req2_send), .q_a(q2_a), .q_b(q2_b), .save_a_n(save2_a_n), .save_b_n(save2_b_n),
    .tx_data(tx2_data), .tx_valid(tx2_valid), .tx_ready(tx2_ready), .sum_out(sum2_out), .busy(busy2)
  );

  // Latch pair model: capture data on the clock edge where the strobe is low.
  always @(posedge clk) begin
    if (!save_a_n)  q_a  <= data_in;
    if (!save_b_n)  q_b  <= data_in;
    if (!save2_a_n) q2_a <= data2;
    if (!save2_b_n) q2_b <= data2;
  end

  int         n_cmp = 0, n_err = 0;
  int         exp_q[$];
  int         sum_q[$];
  int         got2[$];
  int         a_m = 0, b_m = 0;
  int         ready_mode = 0;
  string      hexs = "0123456789ABCDEF";

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int hi_char(input int s);
    return (s >= 16) ? 'h31 : 'h30;
  endfunction

  function automatic int lo_char(input int s);
    return int'(hexs[s % 16]);
  endfunction

  function automatic void push_send(input int s);
    exp_q.push_back(hi_char(s));
    exp_q.push_back(lo_char(s));
    exp_q.push_back('h0D);
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int which, input string name);
    int quiet = 0;
    int n = 0;
    while (quiet < 3 && n < 400) begin
      @(negedge clk);
      n++;
      if ((which == 0 ? busy : busy2) == 1'b0) quiet++;
      else quiet = 0;
    end
    check({name, "_idle"}, int'(quiet >= 3), 1);
  endtask

  task automatic do_op(input bit a, input bit b, input bit s, input bit late, input logic [3:0] d);
    data_in = d;
    if (a) begin a_m = int'(d); sum_q.push_back(a_m + b_m); end
    if (b) begin b_m = int'(d); sum_q.push_back(a_m + b_m); end
    if (s) push_send(a_m + b_m);
    tick(1);
    req_save_a = a;
    req_save_b = b;
    req_send   = s & ~late;
    if (late && s) begin
      tick(3);
      req_send = 1'b1;
    end
    tick(2);
    req_save_a = 1'b0;
    req_save_b = 1'b0;
    req_send   = 1'b0;
    wait_idle(0, "op");
  endtask

  // tx_ready driver: 0 always ready, 1 random, 2 stall 5 cycles per byte, 3 never ready.
  initial begin
    int stall = 0;
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        2: begin
          if (tx_ready) begin
            tx_ready = 1'b0;
            stall = 0;
          end else if (tx_valid) begin
            stall++;
            if (stall >= 5) tx_ready = 1'b1;
          end
        end
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Byte scoreboard, handshake-hold check and strobe-separation check.
  initial begin
    logic       prev_stall = 1'b0;
    logic       prev_strobe = 1'b0;
    logic [7:0] prev_data = 8'h00;
    int         e;
    forever begin
      @(negedge clk);
      if (!reset && prev_stall) begin
        check("tx_hold_valid", int'(tx_valid), 1);
        check("tx_hold_data", int'(tx_data), int'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL tx_unexpected: got byte 0x%0h, expected none at %0t", tx_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", int'(tx_data), e);
        end
      end
      if (!save_a_n || !save_b_n) begin
        check("strobe_excl", int'(save_a_n | save_b_n), 1);
        check("strobe_gap", int'(prev_strobe), 0);
      end
      prev_stall  = tx_valid && !tx_ready;
      prev_data   = tx_data;
      prev_strobe = !save_a_n || !save_b_n;
    end
  end

  // Sum scoreboard: sum_out must show the new sum three cycles after a strobe.
  initial begin
    int e;
    forever begin
      @(negedge clk);
      if (!save_a_n || !save_b_n) begin
        repeat (3) @(negedge clk);
        if (sum_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sum_unexpected: got strobe with sum 0x%0h, expected none", sum_out);
        end else begin
          e = sum_q.pop_front();
          check("sum_out", int'(sum_out), e);
        end
      end
    end
  end

  always @(negedge clk) if (tx2_valid && tx2_ready) got2.push_back(int'(tx2_data));

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] pat;
    int         n;
    int         act_cnt;
    reset = 1'b1;
    req_save_a = 1'b0; req_save_b = 1'b0; req_send = 1'b0; data_in = 4'h0;
    req2_a = 1'b0; req2_b = 1'b0; req2_send = 1'b0; data2 = 4'h0;
    tick(3);
    @(negedge clk);
    check("reset_outputs", int'({save_a_n, save_b_n, tx_valid, tx_data, sum_out, busy}),
          int'({1'b1, 1'b1, 1'b0, 8'h00, 5'h00, 1'b0}));
    tick(1);
    reset = 1'b0;
    tick(2);

    // Save A with 9: strobe exactly at edge+2, sum at edge+5.
    data_in = 4'h9;
    a_m = 9;
    sum_q.push_back(a_m + b_m);
    req_save_a = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pat[k] = save_a_n;
    end
    check("strobe_a_latency", int'(pat), int'(6'b111011));
    check("sum_a_latency", int'(sum_out), 9);
    tick(1);
    req_save_a = 1'b0;
    wait_idle(0, "save_a");

    // Save B with 7, then send with tx_ready high: three back-to-back bytes.
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 4'h7);
    push_send(a_m + b_m);
    tick(1);
    req_send = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pat[k] = tx_valid;
    end
    check("send_latency", int'(pat), int'(6'b011100));
    tick(1);
    req_send = 1'b0;
    wait_idle(0, "send1");
    check("sum_0x10", int'(sum_out), 'h10);

    // F + F with stalled tx_ready; a second send edge mid-frame is dropped.
    do_op(1'b1, 1'b0, 1'b0, 1'b0, 4'hF);
    do_op(1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
    ready_mode = 2;
    push_send(a_m + b_m);
    tick(1);
    req_send = 1'b1;
    tick(2);
    req_send = 1'b0;
    tick(3);
    req_send = 1'b1;
    tick(2);
    req_send = 1'b0;
    wait_idle(0, "stall_send");
    check("stall_drained", exp_q.size(), 0);

    // Simultaneous edges with 3: A, then B, then send of the new sum.
    ready_mode = 0;
    do_op(1'b1, 1'b1, 1'b1, 1'b0, 4'h3);
    check("simul_drained", exp_q.size(), 0);

    // Random operations, random back-pressure.
    ready_mode = 1;
    for (int i = 0; i < 40; i++) begin
      int m = $urandom_range(1, 7);
      do_op(m[0], m[1], m[2], 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end
    check("random_drained", exp_q.size() + sum_q.size(), 0);

    // Reset during SEND_LO with request levels held high.
    ready_mode = 2;
    push_send(a_m + b_m);
    tick(1);
    req_send = 1'b1;
    tick(2);
    req_send = 1'b0;
    n = 0;
    while (!(exp_q.size() == 2 && tx_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reached_send_lo", int'(n < 100), 1);
    @(negedge clk);
    ready_mode = 3;
    tick(1);
    reset = 1'b1;
    req_save_a = 1'b1; req_save_b = 1'b1; req_send = 1'b1;
    exp_q.delete();
    @(negedge clk);
    @(negedge clk);
    check("reset_drop_valid", int'(tx_valid), 0);
    check("reset_drop_busy", int'(busy), 0);
    tick(3);
    reset = 1'b0;
    ready_mode = 0;
    act_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (busy || tx_valid || !save_a_n || !save_b_n) act_cnt++;
    end
    check("no_seq_after_reset", act_cnt, 0);
    tick(1);
    req_save_a = 1'b0; req_save_b = 1'b0; req_send = 1'b0;
    wait_idle(0, "post_reset");

    // AUTO_SEND=1, SEND_CR=0 instance: 5 + 7 = 0x0C sent as two bytes.
    data2 = 4'h5;
    tick(1);
    req2_a = 1'b1;
    tick(2);
    req2_a = 1'b0;
    wait_idle(1, "auto_a");
    data2 = 4'h7;
    req2_b = 1'b1;
    tick(2);
    req2_b = 1'b0;
    wait_idle(1, "auto_b");
    check("auto_count", got2.size(), 2);
    if (got2.size() >= 2) begin
      check("auto_hi", got2[0], hi_char(5 + 7));
      check("auto_lo", got2[1], lo_char(5 + 7));
    end
    check("auto_busy", int'(busy2), 0);
    check("auto_sum", int'(sum2_out), 5 + 7);

    check("final_queues", exp_q.size() + sum_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sum_latch_seq_ctrl.md
Name: sum_latch_seq_ctrl

Overview:
Sequencer for the 2x8 nibble latch pair and the UART transmitter in the SumLatchUART system. It converts user request levels into active-low save strobes for latch A and latch B, then reads back both latched nibbles and forms their 5-bit sum. On a send request it streams the sum over the UART TX valid/ready interface as two ASCII hex characters plus an optional CR. It sits between the tt_um top-level pins and the latch/UART instances.

Parameters:
SEND_CR, 1, 1 = append 0x0D after the two hex characters; 0 = send two bytes only
AUTO_SEND, 0, 1 = a completed save_b sequence automatically starts a send

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req_save_a  in  1  level request (already synchronised); rising edge = save data_in into latch A
req_save_b  in  1  level request; rising edge = save data_in into latch B
req_send  in  1  level request; rising edge = transmit current sum
q_a  in  4  latch A output
q_b  in  4  latch B output
save_a_n  out  1  active-low one-cycle save strobe to latch A
save_b_n  out  1  active-low one-cycle save strobe to latch B
tx_data  out  8  byte to UART TX
tx_valid  out  1  byte valid
tx_ready  in  1  UART TX accepts a byte when tx_valid && tx_ready
sum_out  out  5  registered q_a+q_b, for display
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values, held while reset=1:
  - save_a_n=1, save_b_n=1
  - tx_valid=0, tx_data=0x00
  - sum_out=0, busy=0
  - state=IDLE; edge-detect flops loaded with the current request levels, so no spurious edge is seen after reset; pending flags cleared.
- Edge detect: one flop per request. An edge is registered as a pending flag in cycle N, the cycle in which the request is high and was low in N-1.
- Pending flags:
  - pend_a, pend_b, pend_send, each set by its edge.
  - A flag is cleared only when its sequence is launched from IDLE.
  - A repeated edge while the flag is already set is absorbed.
  - Save edges arriving while busy are retained.
  - Send edges arriving during SEND_* states are dropped; during other busy states they are retained.
- Priority out of IDLE: pend_a > pend_b > pend_send. One sequence is launched per IDLE visit.
- FSM states: IDLE, STROBE_A, STROBE_B, SETTLE, CAPTURE, SEND_HI, SEND_LO, SEND_CR.
  - IDLE -> STROBE_A or STROBE_B: the strobe is low for exactly that one cycle; the latch captures data_in on that clk edge.
  - STROBE_x -> SETTLE (1 cycle) -> CAPTURE.
  - CAPTURE: sum_out <= {1'b0,q_a}+{1'b0,q_b}, zero-extended with no overflow. If the sequence was B and AUTO_SEND=1, go to SEND_HI; otherwise go to IDLE.
  - IDLE with pend_send -> SEND_HI. sum_out is snapshotted into the tx buffer on entry; later latch saves do not alter the bytes in flight.
  - SEND_HI: tx_data = ASCII of sum[4]; always '0' (0x30) or '1' (0x31).
  - SEND_LO: tx_data = ASCII hex of sum[3:0]: 0-9 -> 0x30+n, A-F -> 0x41+(n-10).
  - SEND_CR: tx_data = 0x0D. Present only if SEND_CR=1; otherwise SEND_LO goes to IDLE.
  - In each SEND state tx_valid=1 and tx_data is stable until the cycle where tx_ready=1. The next state begins the following cycle, with tx_valid held continuously high between bytes.
  - After the last byte is accepted: tx_valid=0, state=IDLE.
- Latency: save edge in cycle N gives a strobe in N+2 and sum_out updated in N+5. Send edge in cycle N (IDLE, no pending saves) gives tx_valid=1 in N+2.
- Simultaneous edges in one cycle: all are flagged. Execution order is A, then B, then send; the send transmits the sum including both new nibbles.
- Reset asserted mid-send: tx_valid drops the next clock edge, the partial frame is abandoned, and no byte is resent after reset.
- save_a_n and save_b_n are never low in the same cycle, and never low in consecutive cycles.

Test Plan:
- Reset, then data_in=0x9, pulse req_save_a -> save_a_n low exactly 1 cycle at N+2; q_a=9; sum_out=0x09 at N+5.
- data_in=0x7, pulse req_save_b, then pulse req_send (tx_ready=1) -> bytes 0x31, 0x30, 0x0D on 3 consecutive cycles; sum_out=0x10.
- q_a=0xF, q_b=0xF, send with tx_ready held low 5 cycles per byte -> tx_valid and tx_data stay stable; bytes 0x31, 0x45, 0x0D; no byte is lost or duplicated.
- req_save_a, req_save_b and req_send rise in the same cycle with data_in=0x3 -> strobe A, then strobe B (never same cycle); send outputs 0x30, 0x36, 0x0D.
- AUTO_SEND=1, SEND_CR=0: save_b with sum 0x0C -> exactly two bytes 0x30, 0x43, then busy=0.
- Assert reset while tx_valid=1 in SEND_LO -> tx_valid=0 and busy=0 next cycle; no further bytes; request levels held high through reset produce no sequence.
